// File: rtl/spi_pkg.sv
// spi_pkg: FSM encoding and frame geometry shared by the SPI slave files
package spi_pkg;
  typedef enum logic [2:0] {IDLE, CMD, RD_FETCH, RD_LOAD, DATA, WAIT_CS} state_e;
  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS = 8;
  localparam int RW_BIT = 7;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: synchronizes one async bit into clk and flags its rising/falling edges
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clk)
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o = level_o & ~prev_q;
  assign fall_o = ~level_o & prev_q;
endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: mode-0 SPI slave decoding 16-bit frames into register-memory read/write strobes
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = FRAME_BITS - CMD_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              frame_done,
  output logic              frame_err
);
  localparam int FW = CMD_BITS + DATA_W;
  localparam int CW = $clog2(FW + 1);
  logic sclk_s, sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall, mosi_s, active, cmd_last, frame_last;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [DATA_W-1:0] shift;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-2:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic rd_q, rd_d, miso_q, miso_d, write_q, write_d, done_q, done_d, err_q, err_d;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst(rst), .async_i(sclk), .level_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst(rst), .async_i(cs_n), .level_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  // mosi only needs the level, kept in step with the sclk synchronizer
  always_ff @(posedge clk)
    mosi_q <= rst ? '0 : {mosi_q[SYNC_STAGES-2:0], mosi};
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  assign shift = {rx_q, mosi_s};
  assign active = state_q inside {CMD, RD_FETCH, RD_LOAD, DATA};
  assign cmd_last = cnt_q == CW'(CMD_BITS - 1);
  assign frame_last = cnt_q == CW'(FW - 1);

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rx_d = rx_q;
    tx_d = tx_q;
    rd_d = rd_q;
    miso_d = miso_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    write_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    if (cs_rise && active) begin
      state_d = IDLE;
      err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (cs_fall) begin
            state_d = CMD;
            cnt_d = '0;
            rx_d = '0;
          end
        end
        CMD: if (sclk_rise) begin
          rx_d = shift[DATA_W-2:0];
          cnt_d = cnt_q + 1'b1;
          if (cmd_last) begin
            addr_d = shift[ADDR_W-1:0];
            rd_d = shift[RW_BIT];
            state_d = shift[RW_BIT] ? RD_FETCH : DATA;
          end
        end
        RD_FETCH: state_d = RD_LOAD;
        RD_LOAD: begin
          tx_d = mem_rdata;
          state_d = DATA;
        end
        DATA: begin
          if (sclk_fall && rd_q) begin
            miso_d = tx_q[DATA_W-1];
            tx_d = tx_q << 1;
          end
          if (sclk_rise) begin
            rx_d = shift[DATA_W-2:0];
            cnt_d = cnt_q + 1'b1;
            if (frame_last) begin
              state_d = WAIT_CS;
              done_d = 1'b1;
              write_d = ~rd_q;
              wdata_d = rd_q ? wdata_q : shift;
            end
          end
        end
        WAIT_CS: begin
          // last read bit stays on the pin until sclk drops
          miso_d = miso_q & sclk_s;
          state_d = cs_s ? IDLE : WAIT_CS;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      rd_q <= 1'b0;
      miso_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      rd_q <= rd_d;
      miso_q <= miso_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      done_q <= done_d;
      err_q <= err_d;
    end

  assign miso = miso_q;
  assign mem_write = write_q;
  assign mem_read = state_q == RD_FETCH;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign frame_done = done_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: drives SPI frames at 8-clk sclk phases against a 16x8 memory model
module tb_spi_slave_ctrl;
  typedef struct {
    logic [15:0] frame;
    int extra;
    logic [7:0] exp_miso;
  } vec_t;
  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, mem_write, mem_read, frame_done, frame_err;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [16];
  int n_cmp = 0, n_bad = 0, n_wr = 0, n_rd = 0, n_done = 0, n_err = 0;
  wr_t wq[$];
  logic [3:0] rq[$];
  wr_t we;
  logic [3:0] ra;
  vec_t vt[10];

  always #5 clk = ~clk;

  spi_slave_ctrl #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .frame_done(frame_done), .frame_err(frame_err)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_read ? mem[mem_addr] : 8'h00;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (mem_write) begin
      n_wr++;
      check("wr_rd_exclusive", {31'd0, mem_read}, 0);
      check("done_with_write", {31'd0, frame_done}, 1);
      check("wr_pending", {31'd0, wq.size() != 0}, 1);
      if (wq.size() != 0) begin
        we = wq.pop_front();
        check("wr_addr", {28'd0, mem_addr}, {28'd0, we.addr});
        check("wr_data", {24'd0, mem_wdata}, {24'd0, we.data});
      end
    end
    if (mem_read) begin
      n_rd++;
      check("rd_pending", {31'd0, rq.size() != 0}, 1);
      if (rq.size() != 0) begin
        ra = rq.pop_front();
        check("rd_addr", {28'd0, mem_addr}, {28'd0, ra});
      end
    end
  end

  task automatic sbit(input logic b, output logic m);
    mosi = b;
    repeat (8) @(negedge clk);
    sclk = 1'b1;
    m = miso;
    repeat (8) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic outputs_zero(input string nm);
    check(nm, {13'd0, miso, mem_write, mem_read, mem_addr, mem_wdata, frame_done, frame_err}, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int wr0, rd0, d0, e0;
    logic [7:0] rx;
    logic side, m;
    wr0 = n_wr; rd0 = n_rd; d0 = n_done; e0 = n_err;
    rx = 8'h00;
    side = 1'b0;
    if (v.frame[15]) rq.push_back(v.frame[11:8]);
    else wq.push_back({v.frame[11:8], v.frame[7:0]});
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      sbit(v.frame[15-i], m);
      if (i >= 8) rx = {rx[6:0], m};
      else side |= m;
    end
    for (int i = 0; i < v.extra; i++) begin
      sbit(1'b1, m);
      side |= m;
    end
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check("wr_count", n_wr - wr0, v.frame[15] ? 0 : 1);
    check("rd_count", n_rd - rd0, v.frame[15] ? 1 : 0);
    check("done_count", n_done - d0, 1);
    check("err_count", n_err - e0, 0);
    check("miso_quiet", {31'd0, side}, 0);
    check("miso_data", {24'd0, rx}, {24'd0, v.exp_miso});
  endtask

  initial begin
    int wr0, d0, e0;
    logic m;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    vt[0] = '{16'h03A5, 0, 8'h00};
    vt[1] = '{16'h8300, 0, 8'hA5};
    vt[2] = '{16'h7A99, 0, 8'h00};
    vt[3] = '{16'h8A00, 0, 8'h99};
    vt[4] = '{16'h0F3C, 4, 8'h00};
    vt[5] = '{16'h8F00, 0, 8'h3C};
    vt[6] = '{16'h0000, 0, 8'h00};
    vt[7] = '{16'h80FF, 0, 8'h00};
    vt[8] = '{16'h01FF, 0, 8'h00};
    vt[9] = '{16'h8100, 0, 8'hFF};
    repeat (4) @(negedge clk);
    outputs_zero("reset_outputs");
    rst = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 10; k++) run_vec(vt[k]);

    // abort after 10 bits: no write, one error pulse
    wr0 = n_wr; d0 = n_done; e0 = n_err;
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) sbit(i < 5 ? 1'b0 : 1'b1, m);
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_wr", n_wr - wr0, 0);
    check("abort_err", n_err - e0, 1);
    check("abort_done", n_done - d0, 0);
    run_vec('{16'h0511, 0, 8'h00});
    run_vec('{16'h8500, 0, 8'h11});

    // reset after 12 bits of 0x0742 with cs_n still low
    wr0 = n_wr; d0 = n_done; e0 = n_err;
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      logic [15:0] f;
      f = 16'h0742;
      sbit(f[15-i], m);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    outputs_zero("midframe_reset_outputs");
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (12) @(negedge clk);
    check("reset_wr", n_wr - wr0, 0);
    check("reset_err", n_err - e0, 0);
    check("reset_done", n_done - d0, 0);
    run_vec('{16'h0742, 0, 8'h00});
    run_vec('{16'h8700, 0, 8'h42});

    check("wq_drained", wq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
